uart_tx: RTL and testbench

Byte-wide UART transmitter (8N1) that serializes a parallel byte onto a single line with one start bit, eight data bits LSB first, and one stop bit. It is the transmitting end of the team's serial link and pairs with the D-flip-flop-based receive/capture path. Upstream logic hands over one byte per frame through a valid/ready handshake. An internal baud counter times every bit from `clk`.

---
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a valid/ready byte handshake.
// One start bit (low), eight data bits LSB first, one stop bit (high). Every
// bit is held for CLKS_PER_BIT clocks, timed by an internal baud counter.
// tx and busy are registered, so the line never glitches. tx_ready is a pure
// function of busy and has no combinational path from tx_valid.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,  // clocks per serial bit, >= 2
  parameter int CNT_W        = 16   // baud counter width, 2**CNT_W > CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,       // synchronous, active-high
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Counter value on the last clock of a bit period.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_idx,   w_idx_nxt;
  logic [7:0]       r_sh,    w_sh_nxt;
  logic             r_tx,    w_tx_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             w_bit_end;
  logic             w_accept;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign tx_ready  = ~r_busy;
  assign w_accept  = tx_valid & tx_ready;
  assign busy      = r_busy;
  assign tx        = r_tx;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every target gets a hold value first, so paths that do not assign
    // it cannot infer a latch; blocking '=' is correct in combinational logic.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;

    unique case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (w_accept) begin
          // Byte captured here; later tx_data changes cannot reach the frame.
          // The start bit begins on this same edge (zero latency).
          w_sh_nxt    = tx_data;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_tx_nxt    = r_sh[0];
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_idx != 3'd7) begin
            // Bit 0 of the shifter is the bit on the line; sh[1] is the next.
            w_sh_nxt  = r_sh >> 1;
            w_tx_nxt  = r_sh[1];
            w_idx_nxt = r_idx + 3'd1;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          // Line stays high; the next acceptance can come one edge later.
          w_cnt_nxt   = '0;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_sh    <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_sh    <= w_sh_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with two instances, C=4 and C=2.
// The driver pushes each accepted byte's expected 10-bit frame into a queue;
// a per-instance line monitor pops it when a start bit appears and checks
// every clock of every bit, plus busy/tx_ready around the frame.
module tb_uart_tx;

  localparam int C4 = 4;
  localparam int C2 = 2;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // frame[0] = start, frame[8:1] = data, frame[9] = stop
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d4, d2;
  logic       v4, v2;
  logic       r4, b4, t4;
  logic       r2, b2, t2;
  logic       rst_edge = 1'b1;

  int         n_tests  = 0;
  int         n_fail   = 0;
  int         frames4  = 0;
  int         frames2  = 0;
  int         aborts4  = 0;
  logic [9:0] q4[$];
  logic [9:0] q2[$];
  longint     t_acc;
  longint     t_first;

  always #5 clk = ~clk;

  // Value of rst seen by the most recent rising edge.
  always @(posedge clk) rst_edge <= rst;

  uart_tx #(.CLKS_PER_BIT(C4), .CNT_W(3)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (d4),
    .tx_valid (v4),
    .tx_ready (r4),
    .busy     (b4),
    .tx       (t4)
  );

  uart_tx #(.CLKS_PER_BIT(C2), .CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (d2),
    .tx_valid (v2),
    .tx_ready (r2),
    .busy     (b2),
    .tx       (t2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_tx(input bit sel);
    return sel ? t2 : t4;
  endfunction

  function automatic logic m_busy(input bit sel);
    return sel ? b2 : b4;
  endfunction

  function automatic logic m_ready(input bit sel);
    return sel ? r2 : r4;
  endfunction

  // Line monitor: waits for a start bit, then checks all 10*C samples.
  task automatic monitor(input bit sel);
    int         c;
    logic [9:0] f;
    bit         aborted;
    bit         ok;
    c = sel ? C2 : C4;
    forever begin
      @(negedge clk);
      if (m_tx(sel) === 1'b0 && !rst_edge) begin
        if ((sel ? q2.size() : q4.size()) == 0) begin
          check($sformatf("c%0d_unexpected_frame", c), 32'd1, 32'd0);
          for (int k = 0; k < 20 * c && m_busy(sel) !== 1'b0; k++) @(negedge clk);
        end else begin
          f       = sel ? q2.pop_front() : q4.pop_front();
          aborted = 1'b0;
          for (int b = 0; b < 10 && !aborted; b++) begin
            ok = 1'b1;
            for (int k = 0; k < c; k++) begin
              if (!(b == 0 && k == 0)) @(negedge clk);
              if (rst_edge) begin
                aborted = 1'b1;
                break;
              end
              if (m_tx(sel) !== f[b] || m_busy(sel) !== 1'b1 || m_ready(sel) !== 1'b0) ok = 1'b0;
            end
            if (!aborted)
              check($sformatf("c%0d_byte%02h_bit%0d_held", c, f[8:1], b), {31'd0, ok}, 32'd1);
          end
          if (aborted) begin
            check($sformatf("c%0d_reset_abort_line", c), {30'd0, m_tx(sel), m_busy(sel)}, 32'b10);
            if (!sel) aborts4++;
          end else begin
            @(negedge clk);
            check($sformatf("c%0d_byte%02h_end_tx_busy_ready", c, f[8:1]),
                  {29'd0, m_tx(sel), m_busy(sel), m_ready(sel)}, 32'b101);
            if (sel) frames2++; else frames4++;
          end
        end
      end
    end
  endtask

  // Offer a byte; on acceptance push its frame. Entered and left at posedge+1.
  task automatic send(input bit sel, input logic [7:0] d, input logic [9:0] f, input bit hold);
    bit got;
    got = 1'b0;
    if (sel) begin d2 = d; v2 = 1'b1; end else begin d4 = d; v4 = 1'b1; end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (m_ready(sel) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check($sformatf("accept_timeout_%02h", d), 32'd0, 32'd1);
      if (sel) v2 = 1'b0; else v4 = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      t_acc = $time;
      #1;
      if (sel) q2.push_back(f); else q4.push_back(f);
      if (!hold) begin
        if (sel) v2 = 1'b0; else v4 = 1'b0;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h3C, 10'b1_00111100_0};
    vecs[2] = '{8'h81, 10'b1_10000001_0};
    vecs[3] = '{8'h55, 10'b1_01010101_0};
    vecs[4] = '{8'h00, 10'b1_00000000_0};
    vecs[5] = '{8'hFF, 10'b1_11111111_0};

    fork
      monitor(1'b0);
      monitor(1'b1);
    join_none

    // Reset, with a handshake offered during reset that must be refused.
    rst = 1'b1;
    d4  = 8'hAA; v4 = 1'b1;
    d2  = 8'hAA; v2 = 1'b1;
    cycles(2);
    check("reset_refuses_handshake_c4", {31'd0, b4}, 32'd0);
    check("reset_refuses_handshake_c2", {31'd0, b2}, 32'd0);
    v4 = 1'b0; v2 = 1'b0;
    cycles(1);
    rst = 1'b0;
    check("reset_state_c4_tx_busy_ready", {29'd0, t4, b4, r4}, 32'b101);
    check("reset_state_c2_tx_busy_ready", {29'd0, t2, b2, r2}, 32'b101);
    cycles(3);
    check("idle_no_valid_c4", {29'd0, t4, b4, r4}, 32'b101);

    // Table of single frames at C=4, each a one-cycle tx_valid pulse.
    for (int i = 0; i < 6; i++) begin
      send(1'b0, vecs[i].data, vecs[i].frame, 1'b0);
      cycles(10 * C4 + 3);
    end
    check("table_frames_c4", frames4, 32'd6);

    // Back-to-back: valid held, data switched right after first acceptance.
    send(1'b0, 8'h00, 10'b1_00000000_0, 1'b1);
    t_first = t_acc;
    d4 = 8'hFF;
    send(1'b0, 8'hFF, 10'b1_11111111_0, 1'b0);
    check("b2b_accept_pitch_cycles", 32'((t_acc - t_first) / 10), 32'd41);
    cycles(10 * C4 + 3);
    check("b2b_frames_c4", frames4, 32'd8);

    // Valid pulse while busy is ignored.
    send(1'b0, 8'h3C, 10'b1_00111100_0, 1'b0);
    cycles(9);
    d4 = 8'hFF; v4 = 1'b1;
    cycles(1);
    v4 = 1'b0;
    check("valid_while_busy_still_busy", {31'd0, b4}, 32'd1);
    cycles(10 * C4 + 10);
    check("valid_while_busy_frames", frames4, 32'd9);

    // tx_data changes after acceptance do not affect the frame.
    send(1'b0, 8'h81, 10'b1_10000001_0, 1'b0);
    d4 = 8'h7E;
    cycles(10 * C4 + 3);
    d4 = 8'h00;
    check("data_change_frames", frames4, 32'd10);

    // Reset mid-frame at cycle 18 aborts immediately.
    send(1'b0, 8'hF0, 10'b1_11110000_0, 1'b0);
    cycles(17);
    check("pre_reset_bit3_low", {30'd0, t4, b4}, 32'b01);
    rst = 1'b1;
    cycles(1);
    check("mid_reset_tx_busy_ready", {29'd0, t4, b4, r4}, 32'b101);
    rst = 1'b0;
    cycles(50);
    check("mid_reset_abort_seen", aborts4, 32'd1);
    check("mid_reset_line_idle", {29'd0, t4, b4, r4}, 32'b101);
    send(1'b0, 8'h55, 10'b1_01010101_0, 1'b0);
    cycles(10 * C4 + 3);
    check("post_reset_frames", frames4, 32'd11);

    // C=2 corner: single frame, then back-to-back pitch of 21.
    send(1'b1, 8'h01, 10'b1_00000001_0, 1'b0);
    cycles(10 * C2 + 3);
    check("c2_single_frame", frames2, 32'd1);
    send(1'b1, 8'hB4, 10'b1_10110100_0, 1'b1);
    t_first = t_acc;
    d2 = 8'h4B;
    send(1'b1, 8'h4B, 10'b1_01001011_0, 1'b0);
    check("c2_b2b_accept_pitch_cycles", 32'((t_acc - t_first) / 10), 32'd21);
    cycles(10 * C2 + 3);
    check("c2_frames", frames2, 32'd3);

    check("q4_drained", q4.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
